sample_frame_sequencer: RTL and testbench

- Parametrised successor of the FFT input-sample counter.
- Counts accepted input samples into frames of SAMPLES_PER_FRAME and ping-pongs frames across NUM_BANKS buffer banks.
- Handshakes with the upstream sampler (valid/ready) and with the downstream FFT core (frame_done/frame_ack).
- Drives the per-sample shift strobe that loads the input shift register, and flags overruns.

---
 rtl/fft_in_pkg.sv | 13 +
 rtl/flex_counter.sv | 46 ++++
 rtl/sample_frame_sequencer.sv | 153 +++++++++++++++
 tb/tb_sample_frame_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_in_pkg.sv
// Shared types and defaults for the FFT input-sample frame sequencer.
package fft_in_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } seq_state_t;

  localparam int DEFAULT_SAMPLES_PER_FRAME = 48;
  localparam int DEFAULT_NUM_BANKS         = 2;

endpackage

// File: rtl/flex_counter.sv
// Up-counter that wraps to zero after rollover_val-1, with a synchronous clear.
// rollover_flag marks the enabled cycle in which the terminal count is consumed.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS:0]   rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;
  logic                    atLast;

  // Terminal-count detect; rollover_val is one bit wider so it can hold a power of two.
  always_comb begin
    atLast = ({1'b0, count_q} == (rollover_val - 1'b1));
  end

  // Next count: clear wins, otherwise step and wrap at the terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = atLast ? '0 : count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = count_enable & atLast;

endmodule

// File: rtl/sample_frame_sequencer.sv
// Counts accepted input samples into frames and rotates completed frames through
// a ring of buffer banks, handshaking with the sampler upstream and the FFT core
// downstream. Overruns and stray acknowledges raise a sticky overflow flag.
module sample_frame_sequencer
  import fft_in_pkg::*;
#(
  parameter int SAMPLES_PER_FRAME = DEFAULT_SAMPLES_PER_FRAME,
  parameter int NUM_BANKS         = DEFAULT_NUM_BANKS,
  parameter int DROP_ON_FULL      = 0,
  parameter int CNT_W             = $clog2(SAMPLES_PER_FRAME),
  parameter int BANK_W            = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              shift_strobe,
  output logic [CNT_W-1:0]  sample_count,
  output logic [BANK_W-1:0] write_bank,
  output logic              frame_done,
  output logic [BANK_W-1:0] done_bank,
  input  logic              frame_ack,
  output logic [BANK_W:0]   banks_full,
  output logic              overflow
);

  localparam logic [CNT_W:0]    ROLLOVER   = SAMPLES_PER_FRAME[CNT_W:0];
  localparam logic [BANK_W:0]   FULL_LEVEL = NUM_BANKS[BANK_W:0];
  localparam int                LAST_IDX   = NUM_BANKS - 1;
  localparam logic [BANK_W-1:0] LAST_BANK  = LAST_IDX[BANK_W-1:0];
  localparam bit                DROP       = (DROP_ON_FULL != 0);

  seq_state_t        state_q, state_d;
  logic [BANK_W-1:0] writeBank_q, writeBank_d;
  logic [BANK_W:0]   banksFull_q, banksFull_d;
  logic              frameDone_q, frameDone_d;
  logic [BANK_W-1:0] doneBank_q, doneBank_d;
  logic              overflow_q, overflow_d;

  logic readyInt;
  logic strobeInt;
  logic frameComplete;
  logic counterClear;
  logic ackValid;
  logic ackStray;
  logic dropSample;

  // Readiness depends only on the registered state and the run/abort controls.
  always_comb begin
    readyInt = 1'b0;
    case (state_q)
      IDLE:    readyInt = 1'b0;
      FILL:    readyInt = enable & ~clear;
      STALL:   readyInt = DROP;
      default: readyInt = 1'b0;
    endcase
  end

  // Samples are only taken while filling; in a dropping stall ready is high but nothing loads.
  always_comb begin
    strobeInt  = sample_valid & readyInt & (state_q == FILL);
    dropSample = DROP & (state_q == STALL) & sample_valid;
    ackValid   = frame_ack & (banksFull_q != '0);
    ackStray   = frame_ack & (banksFull_q == '0);
  end

  assign counterClear = clear | frameComplete;

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) sampleCounter (
    .clk           (clk),
    .reset         (reset),
    .clear         (counterClear),
    .count_enable  (strobeInt),
    .rollover_val  (ROLLOVER),
    .count_out     (sample_count),
    .rollover_flag (frameComplete)
  );

  // Bank bookkeeping, completion pulse and state transitions for the next edge.
  always_comb begin
    banksFull_d = banksFull_q;
    case ({frameComplete, ackValid})
      2'b10:   banksFull_d = banksFull_q + 1'b1;
      2'b01:   banksFull_d = banksFull_q - 1'b1;
      default: banksFull_d = banksFull_q;
    endcase

    writeBank_d = writeBank_q;
    if (frameComplete) begin
      writeBank_d = (writeBank_q == LAST_BANK) ? '0 : writeBank_q + 1'b1;
    end

    frameDone_d = frameComplete;
    doneBank_d  = frameComplete ? writeBank_q : doneBank_q;
    overflow_d  = overflow_q | ackStray | dropSample;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = (banksFull_d == FULL_LEVEL) ? STALL : FILL;
        end
      end
      FILL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frameComplete && (banksFull_d == FULL_LEVEL)) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (ackValid) begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered FSM and outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      writeBank_q <= '0;
      banksFull_q <= '0;
      frameDone_q <= 1'b0;
      doneBank_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      writeBank_q <= writeBank_d;
      banksFull_q <= banksFull_d;
      frameDone_q <= frameDone_d;
      doneBank_q  <= doneBank_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sample_ready = readyInt;
  assign shift_strobe = strobeInt;
  assign write_bank   = writeBank_q;
  assign frame_done   = frameDone_q;
  assign done_bank    = doneBank_q;
  assign banks_full   = banksFull_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_sample_frame_sequencer.sv
// Directed bench for the frame sequencer: one back-pressure instance and one
// dropping instance share the same stimulus.
module tb_sample_frame_sequencer;

  localparam int SPF = 48;
  localparam int NB  = 2;
  localparam int CW  = 6;
  localparam int BW  = 1;
  localparam bit H   = 1'b1;
  localparam bit L   = 1'b0;

  typedef struct {
    bit rst;
    bit en;
    bit clr;
    bit vld;
    bit ack;
    int reps;
    bit eRdy;
    bit eStb;
    int eCnt;
    int eWb;
    bit eFd;
    int eDb;
    int eBf;
    bit eOvf;
  } vec_t;

  logic clk = 1'b0;
  logic reset, enable, clear, sampleValid, frameAck;

  logic          ready0, strobe0, fd0, ovf0;
  logic [CW-1:0] count0;
  logic [BW-1:0] wb0, db0;
  logic [BW:0]   bf0;

  logic          ready1, strobe1, fd1, ovf1;
  logic [CW-1:0] count1;
  logic [BW-1:0] wb1, db1;
  logic [BW:0]   bf1;

  int   errors = 0;
  int   checks = 0;
  logic pRdy0, pRdy1, pStb0, pStb1;
  int   stbCnt0 = 0;
  int   stbCnt1 = 0;
  vec_t vecs[$];

  // Free-running clock.
  always #5 clk = ~clk;

  sample_frame_sequencer #(
    .SAMPLES_PER_FRAME (SPF),
    .NUM_BANKS         (NB),
    .DROP_ON_FULL      (0)
  ) dut0 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .sample_valid (sampleValid),
    .sample_ready (ready0),
    .shift_strobe (strobe0),
    .sample_count (count0),
    .write_bank   (wb0),
    .frame_done   (fd0),
    .done_bank    (db0),
    .frame_ack    (frameAck),
    .banks_full   (bf0),
    .overflow     (ovf0)
  );

  sample_frame_sequencer #(
    .SAMPLES_PER_FRAME (SPF),
    .NUM_BANKS         (NB),
    .DROP_ON_FULL      (1)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .sample_valid (sampleValid),
    .sample_ready (ready1),
    .shift_strobe (strobe1),
    .sample_count (count1),
    .write_bank   (wb1),
    .frame_done   (fd1),
    .done_bank    (db1),
    .frame_ack    (frameAck),
    .banks_full   (bf1),
    .overflow     (ovf1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, capture combinational outputs, then settle past posedge.
  task automatic applyStimulus(input bit r, input bit e, input bit c, input bit v, input bit a);
    @(negedge clk);
    reset       = r;
    enable      = e;
    clear       = c;
    sampleValid = v;
    frameAck    = a;
    #1;
    pRdy0 = ready0;
    pRdy1 = ready1;
    pStb0 = strobe0;
    pStb1 = strobe1;
    if (strobe0 === 1'b1) stbCnt0++;
    if (strobe1 === 1'b1) stbCnt1++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    clear       = 1'b0;
    sampleValid = 1'b0;
    frameAck    = 1'b0;

    //            rst en clr vld ack reps rdy stb cnt wb fd db bf ovf
    vecs.push_back('{H, L, L, L, L,  1,  L, L,  0, 0, L, 0, 0, L});
    vecs.push_back('{L, H, L, L, L,  1,  L, L,  0, 0, L, 0, 0, L});
    vecs.push_back('{L, H, L, H, L, 47,  H, H, 47, 0, L, 0, 0, L});
    vecs.push_back('{L, H, L, H, L,  1,  H, H,  0, 1, H, 0, 1, L});
    vecs.push_back('{L, H, L, L, L,  1,  H, L,  0, 1, L, 0, 1, L});
    vecs.push_back('{L, H, L, H, L, 48,  H, H,  0, 0, H, 1, 2, L});
    vecs.push_back('{L, H, L, H, L,  3,  L, L,  0, 0, L, 1, 2, L});
    vecs.push_back('{L, H, L, H, H,  1,  L, L,  0, 0, L, 1, 1, L});
    vecs.push_back('{L, H, L, H, L,  1,  H, H,  1, 0, L, 1, 1, L});
    vecs.push_back('{L, H, L, H, L, 19,  H, H, 20, 0, L, 1, 1, L});
    vecs.push_back('{L, H, H, H, L,  1,  L, L,  0, 0, L, 1, 1, L});
    vecs.push_back('{L, H, L, H, L, 47,  H, H, 47, 0, L, 1, 1, L});
    vecs.push_back('{L, H, L, H, H,  1,  H, H,  0, 1, H, 0, 1, L});
    vecs.push_back('{L, H, L, L, L,  1,  H, L,  0, 1, L, 0, 1, L});
    vecs.push_back('{L, H, L, L, H,  1,  H, L,  0, 1, L, 0, 0, L});
    vecs.push_back('{L, H, L, L, H,  1,  H, L,  0, 1, L, 0, 0, H});
    vecs.push_back('{L, L, L, L, L,  1,  L, L,  0, 1, L, 0, 0, H});
    vecs.push_back('{L, H, L, H, L,  1,  L, L,  0, 1, L, 0, 0, H});
    vecs.push_back('{H, H, L, H, L,  1,  H, H,  0, 0, L, 0, 0, L});

    applyStimulus(H, L, L, L, L);
    applyStimulus(H, L, L, L, L);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].vld, vecs[i].ack);
      end
      checkOutput($sformatf("v%0d ready", i),      pRdy0,  vecs[i].eRdy);
      checkOutput($sformatf("v%0d strobe", i),     pStb0,  vecs[i].eStb);
      checkOutput($sformatf("v%0d count", i),      count0, vecs[i].eCnt);
      checkOutput($sformatf("v%0d write_bank", i), wb0,    vecs[i].eWb);
      checkOutput($sformatf("v%0d frame_done", i), fd0,    vecs[i].eFd);
      checkOutput($sformatf("v%0d done_bank", i),  db0,    vecs[i].eDb);
      checkOutput($sformatf("v%0d banks_full", i), bf0,    vecs[i].eBf);
      checkOutput($sformatf("v%0d overflow", i),   ovf0,   vecs[i].eOvf);
    end

    // Full frame strobe count, then fill both banks on both instances.
    applyStimulus(L, H, L, L, L);
    stbCnt0 = 0;
    repeat (SPF) applyStimulus(L, H, L, H, L);
    checkOutput("frame1 strobes", stbCnt0, SPF);
    checkOutput("frame1 done",    fd0,     1);
    checkOutput("frame1 bank",    db0,     0);
    checkOutput("frame1 wbank",   wb0,     1);
    checkOutput("frame1 full",    bf0,     1);
    checkOutput("frame1 count",   count0,  0);
    repeat (SPF) applyStimulus(L, H, L, H, L);
    checkOutput("both full d0", bf0, 2);
    checkOutput("both full d1", bf1, 2);

    // Valid samples against full banks: back-pressure versus drop.
    stbCnt0 = 0;
    stbCnt1 = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(L, H, L, H, L);
      checkOutput($sformatf("stall ready d0 #%0d", k), pRdy0, 0);
      checkOutput($sformatf("stall ready d1 #%0d", k), pRdy1, 1);
    end
    checkOutput("drop strobes d0", stbCnt0, 0);
    checkOutput("drop strobes d1", stbCnt1, 0);
    checkOutput("drop count d0",   count0,  0);
    checkOutput("drop count d1",   count1,  0);
    checkOutput("drop ovf d0",     ovf0,    0);
    checkOutput("drop ovf d1",     ovf1,    1);

    applyStimulus(L, H, L, L, H);
    checkOutput("ack full d0", bf0, 1);
    checkOutput("ack full d1", bf1, 1);
    applyStimulus(L, H, L, L, L);
    checkOutput("refill ready d0", pRdy0, 1);
    checkOutput("refill ready d1", pRdy1, 1);
    checkOutput("sticky ovf d1a",  ovf1,  1);
    repeat (30) applyStimulus(L, H, L, H, L);
    checkOutput("mid count d0",   count0, 30);
    checkOutput("mid count d1",   count1, 30);
    checkOutput("sticky ovf d1b", ovf1,   1);

    // Reset in the middle of a frame.
    applyStimulus(H, H, L, H, L);
    checkOutput("rst count d0", count0, 0);
    checkOutput("rst wb d0",    wb0,    0);
    checkOutput("rst full d0",  bf0,    0);
    checkOutput("rst fd d0",    fd0,    0);
    checkOutput("rst db d0",    db0,    0);
    checkOutput("rst ovf d0",   ovf0,   0);
    checkOutput("rst count d1", count1, 0);
    checkOutput("rst full d1",  bf1,    0);
    checkOutput("rst ovf d1",   ovf1,   0);
    applyStimulus(L, H, L, H, L);
    checkOutput("idle ready d0",  pRdy0,  0);
    checkOutput("idle strobe d0", pStb0,  0);
    checkOutput("idle count d0",  count0, 0);

    // Reset while stalled.
    repeat (2 * SPF) applyStimulus(L, H, L, H, L);
    applyStimulus(L, H, L, H, L);
    checkOutput("stall2 ready d0", pRdy0, 0);
    checkOutput("stall2 full d0",  bf0,   2);
    applyStimulus(H, H, L, H, L);
    checkOutput("stall rst full d0", bf0, 0);
    checkOutput("stall rst fd d0",   fd0, 0);
    checkOutput("stall rst wb d0",   wb0, 0);
    checkOutput("stall rst full d1", bf1, 0);
    applyStimulus(L, L, L, L, L);
    checkOutput("stall rst ready d0", pRdy0, 0);
    checkOutput("stall rst ready d1", pRdy1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
